// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register controller:
// FSM state encoding and default width / timeout values.
package mdr_pkg;

    localparam int MDR_DATA_W  = 32;
    localparam int MDR_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CAPT  = 2'd2,
        ST_FAULT = 2'd3
    } mdr_state_e;

endpackage : mdr_pkg

// File: rtl/mdr_ctrl_if.sv
// Bus / memory-side signal bundle for mdr_ctrl.
// master: the agent driving loads, read starts and memory responses.
// slave : the controller itself.
interface mdr_ctrl_if #(
    parameter int DATA_W = 32
) ();

    logic                  mdr_in;
    logic [DATA_W-1:0]     bus_in;
    logic [DATA_W/8-1:0]   be;
    logic                  rd_start;
    logic                  mem_req;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_par;
    logic [DATA_W-1:0]     q;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  par_err;

    modport master (
        output mdr_in, bus_in, be, rd_start, mem_ack, mem_data, mem_par,
        input  mem_req, q, busy, done, err, par_err
    );

    modport slave (
        input  mdr_in, bus_in, be, rd_start, mem_ack, mem_data, mem_par,
        output mem_req, q, busy, done, err, par_err
    );

endinterface : mdr_ctrl_if

// File: rtl/mdr_byte_reg.sv
// Byte-masked data register. A memory load overwrites the whole word and
// takes priority over a bus load, which only updates enabled bytes.
module mdr_byte_reg #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                bus_load,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   bus_data,
    input  logic                mem_load,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W-1:0]   q
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign q_d[8*gi +: 8] = mem_load              ? mem_data[8*gi +: 8] :
                                    (bus_load && be[gi])  ? bus_data[8*gi +: 8] :
                                                            q_q[8*gi +: 8];
        end
    endgenerate

    // Register the merged word.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule : mdr_byte_reg

// File: rtl/mdr_ctrl.sv
// Memory data register controller: bus-side byte-masked loads plus a
// request/ack memory read with timeout. All outputs are registered.
// Optional feature: define MDR_CTRL_PARITY_EN to check even parity of
// mem_data/mem_par on each accepted ack (sticky par_err).
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int DATA_W  = MDR_DATA_W,
    parameter int TIMEOUT = MDR_TIMEOUT
) (
    input  logic       clk,
    input  logic       clr_n,
    mdr_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_REQ   = ST_REQ;
    localparam logic [1:0] S_CAPT  = ST_CAPT;
    localparam logic [1:0] S_FAULT = ST_FAULT;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              idle_like;
    logic              rd_accept;
    logic              bus_load;
    logic              mem_load;
    logic [DATA_W-1:0] q_w;

    // IDLE and FAULT both accept bus loads and new reads.
    assign idle_like = (state_q == S_IDLE) || (state_q == S_FAULT);
    assign rd_accept = bus.rd_start && idle_like;
    assign bus_load  = bus.mdr_in && idle_like;
    assign mem_load  = (state_q == S_REQ) && bus.mem_ack;

    mdr_byte_reg #(
        .DATA_W (DATA_W)
    ) u_byte_reg (
        .clk      (clk),
        .clr_n    (clr_n),
        .bus_load (bus_load),
        .be       (bus.be),
        .bus_data (bus.bus_in),
        .mem_load (mem_load),
        .mem_data (bus.mem_data),
        .q        (q_w)
    );

    // Next-state logic; an ack in REQ beats a timeout on the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_req_d = mem_req_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_FAULT: begin
                if (rd_accept) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    state_d   = S_CAPT;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    state_d   = S_FAULT;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef MDR_CTRL_PARITY_EN
    logic par_err_q, par_err_d;

    // Sticky parity error, cleared when a new read is accepted.
    always_comb begin
        par_err_d = par_err_q;
        if (rd_accept)
            par_err_d = 1'b0;
        else if (mem_load && (^{bus.mem_data, bus.mem_par}))
            par_err_d = 1'b1;
    end

    // Parity flag register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign bus.par_err = par_err_q;
`else
    logic unused_mem_par;
    assign unused_mem_par = bus.mem_par;
    assign bus.par_err    = 1'b0;
`endif

    assign bus.q       = q_w;
    assign bus.mem_req = mem_req_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule : mdr_ctrl

// File: tb/tb_mdr_ctrl.sv
// Self-checking bench for mdr_ctrl: directed steps followed by random
// loads/reads checked against a word-level reference model.
module tb_mdr_ctrl;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam int NB      = DATA_W / 8;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;

    mdr_ctrl_if #(.DATA_W(DATA_W)) bus ();

    mdr_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q;
    logic              exp_err;
    logic              exp_par_err;
    bit                par_en;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_bus_load(input logic [NB-1:0] be_v, input logic [DATA_W-1:0] d);
        for (int i = 0; i < NB; i++)
            if (be_v[i]) exp_q[8*i +: 8] = d[8*i +: 8];
    endtask

    // Bus load from IDLE or FAULT.
    task automatic bus_load(input logic [NB-1:0] be_v, input logic [DATA_W-1:0] d);
        bus.mdr_in = 1'b1;
        bus.be     = be_v;
        bus.bus_in = d;
        tick();
        bus.mdr_in = 1'b0;
        model_bus_load(be_v, d);
        $display("load be=%b data=%h -> q=%h", be_v, d, bus.q);
        check("load_q", bus.q, exp_q);
        check("load_err", DATA_W'(bus.err), DATA_W'(exp_err));
    endtask

    // Read transaction; ack_at is the index of the mem_req cycle carrying
    // the ack, any value >= TIMEOUT means the memory never answers.
    task automatic read_txn(input int ack_at, input logic [DATA_W-1:0] data, input logic par,
                            input bit side_load, input logic [NB-1:0] side_be,
                            input logic [DATA_W-1:0] side_data);
        int c;
        bit acked;
        bus.rd_start = 1'b1;
        bus.mdr_in   = side_load;
        bus.be       = side_be;
        bus.bus_in   = side_data;
        tick();
        bus.rd_start = 1'b0;
        bus.mdr_in   = 1'b0;
        if (side_load) model_bus_load(side_be, side_data);
        exp_err     = 1'b0;
        exp_par_err = 1'b0;
        check("start_busy", DATA_W'(bus.busy), 1);
        check("start_err", DATA_W'(bus.err), 0);
        check("start_par_err", DATA_W'(bus.par_err), 0);
        check("start_q", bus.q, exp_q);
        c = 0;
        acked = 0;
        while (!acked && c < TIMEOUT) begin
            check("req_held", DATA_W'(bus.mem_req), 1);
            check("req_no_done", DATA_W'(bus.done), 0);
            bus.mdr_in   = 1'($urandom);
            bus.be       = NB'($urandom);
            bus.bus_in   = $urandom;
            bus.rd_start = 1'($urandom);
            if (c == ack_at) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = data;
                bus.mem_par  = par;
                acked        = 1;
            end else begin
                bus.mem_ack  = 1'b0;
                bus.mem_data = $urandom;
                bus.mem_par  = 1'($urandom);
            end
            tick();
            c++;
        end
        bus.mdr_in   = 1'b0;
        bus.rd_start = 1'b0;
        bus.mem_ack  = 1'b0;
        if (acked) begin
            exp_q = data;
            if (par_en && ((^data) ^ par)) exp_par_err = 1'b1;
            $display("read ack_at=%0d data=%h -> q=%h done=%b err=%b par_err=%b",
                     ack_at, data, bus.q, bus.done, bus.err, bus.par_err);
            check("capt_done", DATA_W'(bus.done), 1);
            check("capt_busy", DATA_W'(bus.busy), 1);
            check("capt_req", DATA_W'(bus.mem_req), 0);
            check("capt_q", bus.q, exp_q);
            check("capt_err", DATA_W'(bus.err), 0);
            check("capt_par_err", DATA_W'(bus.par_err), DATA_W'(exp_par_err));
            // rd_start and mdr_in during CAPT must be ignored
            bus.rd_start = 1'b1;
            bus.mdr_in   = 1'b1;
            bus.be       = '1;
            bus.bus_in   = ~data;
            tick();
            bus.rd_start = 1'b0;
            bus.mdr_in   = 1'b0;
            check("post_done", DATA_W'(bus.done), 0);
            check("post_busy", DATA_W'(bus.busy), 0);
            check("post_req", DATA_W'(bus.mem_req), 0);
            check("post_q", bus.q, exp_q);
        end else begin
            exp_err = 1'b1;
            $display("read timeout after %0d cycles -> q=%h err=%b mem_req=%b",
                     c, bus.q, bus.err, bus.mem_req);
            check("to_err", DATA_W'(bus.err), 1);
            check("to_req", DATA_W'(bus.mem_req), 0);
            check("to_busy", DATA_W'(bus.busy), 0);
            check("to_done", DATA_W'(bus.done), 0);
            check("to_q", bus.q, exp_q);
        end
    endtask

    initial begin
`ifdef MDR_CTRL_PARITY_EN
        par_en = 1'b1;
`else
        par_en = 1'b0;
`endif
        bus.mdr_in   = 1'b0;
        bus.bus_in   = '0;
        bus.be       = '0;
        bus.rd_start = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        bus.mem_par  = 1'b0;
        exp_q        = '0;
        exp_err      = 1'b0;
        exp_par_err  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", bus.q, 0);
        check("rst_req", DATA_W'(bus.mem_req), 0);
        check("rst_busy", DATA_W'(bus.busy), 0);
        check("rst_done", DATA_W'(bus.done), 0);
        check("rst_err", DATA_W'(bus.err), 0);
        check("rst_par_err", DATA_W'(bus.par_err), 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Directed bus loads
        bus_load(4'b1111, 32'h2);
        check("load_full", bus.q, 32'h2);
        bus_load(4'b1111, 32'hAABBCCDD);
        bus_load(4'b0101, 32'h11223344);
        check("load_masked", bus.q, 32'hAA22CC44);

        // Ack on second mem_req cycle
        read_txn(1, 32'h3, 1'b0, 0, '0, '0);
        // Minimum latency, ack on first cycle, with simultaneous bus load
        read_txn(0, 32'h0F0F1234, 1'b1, 1, 4'b0011, 32'h55667788);
        // Ack on the very cycle the counter would time out
        read_txn(TIMEOUT - 1, 32'hCAFE0001, 1'b1, 0, '0, '0);
        // Timeout, then bus load in FAULT, then a read clears err
        read_txn(TIMEOUT, 32'h0, 1'b0, 0, '0, '0);
        bus_load(4'b1000, 32'h77000000);
        read_txn(2, 32'h12345678, 1'b1, 0, '0, '0);

        // Parity error case; the next read clears the flag
        read_txn(0, 32'h1, 1'b0, 0, '0, '0);
        check("par_flag", DATA_W'(bus.par_err), DATA_W'(par_en));
        read_txn(0, 32'h3, 1'b0, 0, '0, '0);

        // Ack outside REQ is ignored
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'hDEADBEEF;
        tick();
        bus.mem_ack  = 1'b0;
        check("idle_ack_q", bus.q, exp_q);
        check("idle_ack_done", DATA_W'(bus.done), 0);

        // Random mix
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) == 0)
                bus_load(NB'($urandom), $urandom);
            else
                read_txn(int'($urandom_range(0, TIMEOUT + 2)), $urandom, 1'($urandom),
                         1'($urandom), NB'($urandom), $urandom);
        end

        // Reset in the middle of REQ
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        tick();
        #2 clr_n = 1'b0;
        #1;
        exp_q = '0;
        $display("async reset mid-read -> q=%h req=%b busy=%b", bus.q, bus.mem_req, bus.busy);
        check("arst_q", bus.q, 0);
        check("arst_req", DATA_W'(bus.mem_req), 0);
        check("arst_busy", DATA_W'(bus.busy), 0);
        check("arst_done", DATA_W'(bus.done), 0);
        check("arst_err", DATA_W'(bus.err), 0);
        check("arst_par_err", DATA_W'(bus.par_err), 0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rel_done", DATA_W'(bus.done), 0);
            check("rel_req", DATA_W'(bus.mem_req), 0);
            check("rel_q", bus.q, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mdr_ctrl

// File: doc/mdr_ctrl.md
MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data width; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles mem_req waits for mem_ack; range 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port clr_n  input  1  reset, asynchronous, active-low.
REQ-005 Port mdr_in  input  1  load q from bus_in, byte-masked.
REQ-006 Port bus_in  input  DATA_W  bus-side write data.
REQ-007 Port be  input  DATA_W/8  byte enables for bus loads; bit i covers q[8i+7:8i].
REQ-008 Port rd_start  input  1  start a memory read transaction.
REQ-009 Port mem_req  output  1  memory read request, held until ack or timeout.
REQ-010 Port mem_ack  input  1  memory data valid this cycle.
REQ-011 Port mem_data  input  DATA_W  memory read data.
REQ-012 Port mem_par  input  1  even-parity bit accompanying mem_data.
REQ-013 Port q  output  DATA_W  register contents.
REQ-014 Port busy  output  1  high in REQ and CAPT.
REQ-015 Port done  output  1  one-cycle pulse, read completed.
REQ-016 Port err  output  1  sticky timeout flag.
REQ-017 Port par_err  output  1  sticky parity-error flag.

Function
REQ-018 FSM states IDLE, REQ, CAPT, FAULT; all outputs registered.
REQ-019 IDLE: rd_start=1 -> REQ next edge; mem_req=1 from the following cycle.
REQ-020 REQ: mem_ack=1 -> q<=mem_data on that edge, go CAPT; mem_req drops same edge.
REQ-021 REQ: wait counter increments each cycle without ack; reaching TIMEOUT -> FAULT, err<=1, q unchanged.
REQ-022 CAPT: done=1 for exactly one cycle, then IDLE.
REQ-023 FAULT: err held; rd_start=1 clears err and enters REQ; mdr_in behaves as in IDLE.
REQ-024 mdr_in=1 in IDLE or FAULT: q byte i <= bus_in byte i where be[i]=1, else retained.
REQ-025 mdr_in in REQ or CAPT is ignored; memory path has priority.
REQ-026 mdr_in and rd_start same IDLE cycle: bus load performed, read also started.
REQ-027 rd_start while busy ignored; mem_ack outside REQ ignored.
REQ-028 mem_ack on the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-029 Minimum read latency: rd_start edge to done high = 3 cycles with ack on first mem_req cycle.

Reset
REQ-030 clr_n=0 asynchronously forces IDLE, q=0, mem_req=0, busy=0, done=0, err=0, par_err=0, counter=0.
REQ-031 Reset mid-transaction aborts it; no done pulse after release.
REQ-032 First state change allowed on the first rising edge after clr_n deasserts.

Configuration
REQ-033 Macro MDR_CTRL_PARITY_EN defined: on accepted ack, XOR(mem_data, mem_par)=1 sets par_err (sticky until reset or next rd_start); q still loaded.
REQ-034 Macro undefined: mem_par ignored, par_err constant 0, no parity logic.

Structure
REQ-035 Shared package mdr_pkg holds FSM state enum and default DATA_W/TIMEOUT constants.
REQ-036 Sub-module mdr_byte_reg (byte-masked register with load mux) is natural; FSM in mdr_ctrl.

Verification
REQ-037 Reset then mdr_in=1, be=4'b1111, bus_in=32'h2 -> q=32'h2 next edge.
REQ-038 q=32'hAABBCCDD, mdr_in=1, be=4'b0101, bus_in=32'h11223344 -> q=32'hAA22CC44.
REQ-039 rd_start, ack on 2nd mem_req cycle with mem_data=32'h3 -> q=32'h3, single done pulse, err=0.
REQ-040 rd_start, no ack, TIMEOUT=15 -> err=1 after 15 REQ cycles, mem_req=0, q unchanged; next rd_start clears err.
REQ-041 clr_n low during REQ -> all outputs 0 immediately, no done after release.
REQ-042 With MDR_CTRL_PARITY_EN, mem_data=32'h1, mem_par=0 -> par_err=1, q=32'h1; without macro par_err stays 0.
